load_sequencer: RTL and testbench
=================================

# load_sequencer

Upstream companion to the matrix-converter commutation FSM. Each switching period it generates the `DesiredLoad` code (A, B, C) from per-period duty counts, and the commutation FSM consumes that code. It enforces a minimum dwell per load so the four-step commutation always finishes. It also synchronizes and debounces the raw current-sign comparator into `CurrentSign`, and drives the FSM's `start` enable.

## Interface
Parameters:
- `CNT_W`, 12: width of the period and duty counters.
- `MIN_DWELL`, 8: minimum clocks a non-zero segment must last. Shorter segments are dropped.
- `DB_LEN`, 4: number of consecutive equal synchronized samples needed to change `CurrentSign`.

Ports:
- `clk`, in, 1: single clock. All logic is on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `enable`, in, 1: run request. Level sensitive.
- `period`, in, CNT_W: switching period in clocks. Legal range is ≥ 3·MIN_DWELL.
- `duty_a`, in, CNT_W: clocks per period on load A.
- `duty_b`, in, CNT_W: clocks per period on load B. Load C gets the remainder, period − duty_a − duty_b.
- `load`, in, 1: one-cycle strobe that captures period/duty_a/duty_b into the pending shadow registers.
- `sign_raw`, in, 1: asynchronous current-sign comparator output. 1 means positive.
- `DesiredLoad`, out, 2: 00 = NUL, 01 = A, 10 = B, 11 = C. Registered.
- `CurrentSign`, out, 1: synchronized and filtered sign. Registered.
- `start`, out, 1: enable for the commutation FSM. Registered.
- `period_tick`, out, 1: one-cycle pulse on the first clock of each period.
- `dwell_err`, out, 1: one-cycle pulse when a segment is dropped or a load is rejected.

## Operation
- Reset values: `DesiredLoad`=00, `CurrentSign`=0, `start`=0, `period_tick`=0, `dwell_err`=0. Counters are cleared, the state is IDLE, the active and pending shadows are 0, and the pending-valid flag is clear.
- The state machine has three states: IDLE, ARM, RUN.
  - IDLE: outputs NUL with start=0. Moves to ARM when `enable`=1 and pending-valid=1.
  - ARM, exactly 1 cycle: copies the pending shadow into the active registers and sets start=1. `DesiredLoad` stays NUL. Moves to RUN.
  - RUN: a period counter `cnt` runs 0..period−1 and wraps. At `cnt`=0 the block raises `period_tick` and copies pending into active if a new load arrived.
  - RUN exit: when `enable` drops, the block goes to IDLE on the next clock, with start=0 and `DesiredLoad`=NUL in that same cycle.
- Segment order within a period is fixed: A for [0, da), B for [da, da+db), C for [da+db, period).
- Dwell rule: a segment whose length L satisfies 0 < L < MIN_DWELL is dropped.
  - Its cycles go to the next non-dropped segment in A, B, C order, wrapping to A of the same period if C is dropped.
  - `dwell_err` pulses once at that period's `cnt`=0.
  - Zero-length segments are skipped without an error.
- Load validation happens at `load`:
  - Rejected if duty_a+duty_b > period (sum computed at CNT_W+1 bits) or if period < 3·MIN_DWELL.
  - On rejection the shadow is unchanged and `dwell_err` pulses the next cycle.
  - When `load` and `cnt`=0 coincide, the new values take effect at the following boundary, not the current one.
- Every transition between two non-NUL loads passes through no NUL cycle. The change is a direct code change so the downstream FSM steps through commutation.
- Sign path: 2-FF synchronizer, then the debounce counter (see Configuration). `CurrentSign` updates in every state, including IDLE.
- `rst` mid-period aborts immediately. On the next edge all outputs return to their reset values and the pending shadow is lost.

## Timing
- `DesiredLoad` changes on the clock edge after `cnt` reaches a segment boundary, giving a fixed 1-cycle latency.
- `start` rises 1 cycle before the first non-NUL `DesiredLoad`.
- Sign latency from `sign_raw` to `CurrentSign` is 2 + DB_LEN clocks with the filter in, and 3 clocks with the filter out.
- `period_tick` and a boundary `DesiredLoad`=A update occur on the same edge.

## Configuration
- `LOAD_SEQ_SIGN_FILTER_EN` defined:
  - A saturating counter counts consecutive synchronized samples that differ from `CurrentSign`.
  - `CurrentSign` toggles when the count reaches DB_LEN.
  - Any equal sample resets the count.
- `LOAD_SEQ_SIGN_FILTER_EN` undefined: `CurrentSign` is the synchronizer output plus one register stage, and `DB_LEN` is ignored.

## Test plan
- Basic sequence: period=48, duty_a=16, duty_b=16, load, enable → start=1 at ARM, then DesiredLoad sequence 01×16, 10×16, 11×16 repeating, with period_tick every 48 clocks.
- Dropped segment: period=48, duty_a=5, duty_b=20 (MIN_DWELL=8) → A is dropped, B lasts 25 clocks, C lasts 23, and dwell_err pulses once per period.
- Rejected load: load period=48, duty_a=30, duty_b=30 while running → dwell_err pulses 1 cycle later and the previous schedule continues unchanged.
- Mid-period load: load at cnt=10 → the current period keeps the old duties, and the new duties appear at the next period_tick.
- Sign filter: sign_raw pulses of 1 for 3 clocks are ignored, while a level of 1 held ≥ 6 clocks gives CurrentSign=1 exactly 6 clocks after the edge (filter in, DB_LEN=4).
- Abort: enable low in the middle of segment B → the next clock shows start=0 and DesiredLoad=00. Separately, rst=1 mid-period gives all-reset outputs on the next edge, and IDLE is held until a new load.

Source files
------------

// File: rtl/load_sequencer.sv
// Per-period DesiredLoad generator with minimum-dwell enforcement and sign
// conditioning. Define LOAD_SEQ_SIGN_FILTER_EN to enable the sign debounce.
module load_sequencer #(
  parameter int CNT_W     = 12,
  parameter int MIN_DWELL = 8,
  parameter int DB_LEN    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty_a,
  input  logic [CNT_W-1:0] duty_b,
  input  logic             load,
  input  logic             sign_raw,
  output logic [1:0]       DesiredLoad,
  output logic             CurrentSign,
  output logic             start,
  output logic             period_tick,
  output logic             dwell_err
);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  localparam logic [1:0] NUL = 2'b00;
  localparam logic [1:0] LA  = 2'b01;
  localparam logic [1:0] LB  = 2'b10;
  localparam logic [1:0] LC  = 2'b11;

  localparam logic [CNT_W:0] MIN_LEN = (CNT_W+1)'(MIN_DWELL);
  localparam logic [CNT_W:0] MIN_PER = (CNT_W+1)'(3 * MIN_DWELL);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] act_per, act_a, act_b;
  logic [CNT_W-1:0] pnd_per, pnd_a, pnd_b;
  logic             pnd_valid, pnd_new;
  logic             copy;
  logic [1:0]       dl_d;
  logic             start_d, tick_d, err_d;

  logic [CNT_W:0]   sum_ab, len_a, len_b, len_c, cx, ld_sum;
  logic             keep_a, keep_b, keep_c, any_drop;
  logic             pos_a, pos_b, ld_ok;
  logic [1:0]       seg;

  assign len_a    = {1'b0, act_a};
  assign len_b    = {1'b0, act_b};
  assign sum_ab   = len_a + len_b;
  assign len_c    = {1'b0, act_per} - sum_ab;
  assign keep_a   = len_a >= MIN_LEN;
  assign keep_b   = len_b >= MIN_LEN;
  assign keep_c   = len_c >= MIN_LEN;
  assign any_drop = (len_a != '0 && !keep_a) ||
                    (len_b != '0 && !keep_b) ||
                    (len_c != '0 && !keep_c);
  assign cx       = {1'b0, cnt};
  assign pos_a    = cx < len_a;
  assign pos_b    = !pos_a && (cx < sum_ab);
  assign ld_sum   = {1'b0, duty_a} + {1'b0, duty_b};
  assign ld_ok    = (ld_sum <= {1'b0, period}) &&
                    ({1'b0, period} >= MIN_PER);

  // segment at cnt; a dropped segment hands its cycles to the next kept one
  always_comb begin
    seg = LC;
    unique case (1'b1)
      pos_a:   seg = keep_a ? LA : (keep_b ? LB : LC);
      pos_b:   seg = keep_b ? LB : (keep_c ? LC : LA);
      default: seg = keep_c ? LC : (keep_a ? LA : LB);
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // next state, counter and next registered outputs
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    copy    = 1'b0;
    dl_d    = NUL;
    start_d = 1'b0;
    tick_d  = 1'b0;
    err_d   = load && !ld_ok;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (enable && pnd_valid) begin
          state_d = ARM;
          start_d = 1'b1;
          copy    = 1'b1;
        end
      end
      ARM, RUN: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = RUN;
          start_d = 1'b1;
          dl_d    = seg;
          tick_d  = cnt == '0;
          err_d   = err_d || (cnt == '0 && any_drop);
          if (cnt == act_per - 1'b1) begin
            cnt_d = '0;
            copy  = pnd_new;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // counter, shadows and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      act_per     <= '0;
      act_a       <= '0;
      act_b       <= '0;
      pnd_per     <= '0;
      pnd_a       <= '0;
      pnd_b       <= '0;
      pnd_valid   <= 1'b0;
      pnd_new     <= 1'b0;
      DesiredLoad <= NUL;
      start       <= 1'b0;
      period_tick <= 1'b0;
      dwell_err   <= 1'b0;
    end else begin
      cnt         <= cnt_d;
      DesiredLoad <= dl_d;
      start       <= start_d;
      period_tick <= tick_d;
      dwell_err   <= err_d;
      if (copy) begin
        act_per <= pnd_per;
        act_a   <= pnd_a;
        act_b   <= pnd_b;
        pnd_new <= 1'b0;
      end
      if (load && ld_ok) begin
        pnd_per   <= period;
        pnd_a     <= duty_a;
        pnd_b     <= duty_b;
        pnd_valid <= 1'b1;
        pnd_new   <= 1'b1;
      end
    end
  end

  logic sync1, sync2;

  // two-flop synchronizer for the comparator
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sign_raw;
      sync2 <= sync1;
    end
  end

`ifdef LOAD_SEQ_SIGN_FILTER_EN
  localparam int DB_W = $clog2(DB_LEN + 1);
  logic [DB_W-1:0] db_cnt;

  // toggle after DB_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt      <= '0;
      CurrentSign <= 1'b0;
    end else if (sync2 != CurrentSign) begin
      if (db_cnt == DB_W'(DB_LEN - 1)) begin
        db_cnt      <= '0;
        CurrentSign <= ~CurrentSign;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end
`else
  // unfiltered: one register stage after the synchronizer
  always_ff @(posedge clk) begin
    if (rst) CurrentSign <= 1'b0;
    else     CurrentSign <= sync2;
  end
`endif

endmodule

// File: tb/tb_load_sequencer.sv
// Directed bench for load_sequencer (defaults CNT_W=12, MIN_DWELL=8,
// DB_LEN=4); expected schedules are hand-derived per period.
module tb_load_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic        sign_raw = 1'b0;
  logic [11:0] period = '0;
  logic [11:0] duty_a = '0;
  logic [11:0] duty_b = '0;
  logic [1:0]  DesiredLoad;
  logic        CurrentSign;
  logic        start;
  logic        period_tick;
  logic        dwell_err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  load_sequencer dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .period(period),
    .duty_a(duty_a),
    .duty_b(duty_b),
    .load(load),
    .sign_raw(sign_raw),
    .DesiredLoad(DesiredLoad),
    .CurrentSign(CurrentSign),
    .start(start),
    .period_tick(period_tick),
    .dwell_err(dwell_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)",
                  tag, obs, exp, $time);
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_dl"},    32'(DesiredLoad), 32'd0);
    chk({tag, "_sign"},  32'(CurrentSign), 32'd0);
    chk({tag, "_start"}, 32'(start),       32'd0);
    chk({tag, "_tick"},  32'(period_tick), 32'd0);
    chk({tag, "_err"},   32'(dwell_err),   32'd0);
  endtask

  // one period from its first sample; optional load strobe at k=10
  task automatic expect_period(input int la, input int lb,
                               input int lc, input bit err,
                               input bit inj, input int ip,
                               input int ia, input int ib,
                               input bit rej);
    logic [1:0] e;
    for (int k = 0; k < la + lb + lc; k++) begin
      e = (k < la) ? 2'b01 : (k < la + lb) ? 2'b10 : 2'b11;
      chk("dl",    32'(DesiredLoad), 32'(e));
      chk("tick",  32'(period_tick), 32'(k == 0));
      chk("err",   32'(dwell_err),
          32'(((k == 0) && err) || ((k == 11) && rej)));
      chk("start", 32'(start), 32'd1);
      if (inj && k == 10) begin
        period = 12'(ip);
        duty_a = 12'(ia);
        duty_b = 12'(ib);
        load   = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  initial begin
    tick_n(3);
    chk_reset_outs("rst");
    rst = 1'b0;
    tick_n(2);
    chk("idle_start", 32'(start), 32'd0);

`ifdef LOAD_SEQ_SIGN_FILTER_EN
    sign_raw = 1'b1;
    tick_n(3);
    sign_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("glitch", 32'(CurrentSign), 32'd0);
      @(negedge clk);
    end
    sign_raw = 1'b1;
    tick_n(5);
    chk("sign_early", 32'(CurrentSign), 32'd0);
    tick_n(1);
    chk("sign_edge", 32'(CurrentSign), 32'd1);
`else
    sign_raw = 1'b1;
    tick_n(2);
    chk("sign_early", 32'(CurrentSign), 32'd0);
    tick_n(1);
    chk("sign_edge", 32'(CurrentSign), 32'd1);
`endif

    period = 12'd48;
    duty_a = 12'd16;
    duty_b = 12'd16;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    enable = 1'b1;
    chk("pre_arm_err", 32'(dwell_err), 32'd0);
    @(negedge clk);
    chk("arm_start", 32'(start),       32'd1);
    chk("arm_dl",    32'(DesiredLoad), 32'd0);
    chk("arm_tick",  32'(period_tick), 32'd0);
    @(negedge clk);

    expect_period(16, 16, 16, 0, 0, 0, 0, 0, 0);
    expect_period(16, 16, 16, 0, 1, 48, 5, 20, 0);
    expect_period(0, 25, 23, 1, 1, 48, 30, 30, 1);
    expect_period(0, 25, 23, 1, 0, 0, 0, 0, 0);

    tick_n(15);
    chk("pre_abort_dl", 32'(DesiredLoad), 32'd2);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_start", 32'(start),       32'd0);
    chk("abort_dl",    32'(DesiredLoad), 32'd0);

    enable = 1'b1;
    tick_n(20);
    chk("rerun_start", 32'(start), 32'd1);
    chk("rerun_dl",    32'(DesiredLoad), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("mid_rst");
    rst = 1'b0;
    tick_n(5);
    chk("hold_start", 32'(start),       32'd0);
    chk("hold_dl",    32'(DesiredLoad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
